// File: rtl/axicb_pipeline_chain_pkg.sv
// Shared defaults for the crossbar register-slice chain.
package axicb_pipeline_chain_pkg;

    localparam int AXICB_DATA_W_DEFAULT = 32;
    localparam int AXICB_NB_PIPE_DEFAULT = 1;

endpackage

// File: rtl/axicb_pipeline_chain_stage.sv
// One valid/ready register slice: a main register plus a skid entry.
// The upstream ready only looks at registered state, which breaks the ready path.
module axicb_pipeline_stage
    import axicb_pipeline_chain_pkg::*;
#(
    parameter int DATA_BUS_W = AXICB_DATA_W_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_BUS_W-1:0] i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_BUS_W-1:0] o_data
);

    logic                  main_valid;
    logic [DATA_BUS_W-1:0] main_data;
    logic                  skid_valid;
    logic [DATA_BUS_W-1:0] skid_data;
    logic                  accept;

    assign i_ready = !skid_valid && !srst;
    assign accept  = i_valid && i_ready;
    assign o_valid = main_valid;
    assign o_data  = main_data;

    always_ff @(posedge aclk) begin
        if (srst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!main_valid || o_ready) begin
            // main is free this cycle: the skid entry is older than any new input
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_data <= i_data;
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= i_data;
        end
    end

endmodule

// File: rtl/axicb_pipeline_chain.sv
// Chain of NB_PIPELINE register slices; zero stages collapses to plain wires.
module axicb_pipeline_chain
    import axicb_pipeline_chain_pkg::*;
#(
    parameter int DATA_BUS_W  = AXICB_DATA_W_DEFAULT,
    parameter int NB_PIPELINE = AXICB_NB_PIPE_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_BUS_W-1:0] i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_BUS_W-1:0] o_data
);

    if (NB_PIPELINE == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = aclk ^ srst;
        assign o_valid = i_valid;
        assign o_data  = i_data;
        assign i_ready = o_ready;
    end else begin : g_chain
        logic [NB_PIPELINE:0] valid_w;
        logic [NB_PIPELINE:0] ready_w;
        logic [DATA_BUS_W-1:0] data_w [NB_PIPELINE+1];

        assign valid_w[0] = i_valid;
        assign data_w[0]  = i_data;
        assign i_ready    = ready_w[0];

        for (genvar k = 0; k < NB_PIPELINE; k++) begin : g_stage
            axicb_pipeline_stage #(
                .DATA_BUS_W(DATA_BUS_W)
            ) u_stage (
                .aclk    (aclk),
                .srst    (srst),
                .i_valid (valid_w[k]),
                .i_ready (ready_w[k]),
                .i_data  (data_w[k]),
                .o_valid (valid_w[k+1]),
                .o_ready (ready_w[k+1]),
                .o_data  (data_w[k+1])
            );
        end

        assign o_valid              = valid_w[NB_PIPELINE];
        assign o_data               = data_w[NB_PIPELINE];
        assign ready_w[NB_PIPELINE] = o_ready;
    end

endmodule

// File: tb/tb_axicb_pipeline_chain.sv
// Bench for axicb_pipeline_chain: three instances (0, 1 and 3 stages) checked
// by per-instance expected queues filled on input handshakes.
module tb_axicb_pipeline_chain;

    localparam logic [31:0] KEY = 32'h4A5B3C86;

    logic        aclk;
    logic        srst;
    logic        iv  [3];
    logic        ir  [3];
    logic [31:0] id  [3];
    logic        ov  [3];
    logic        orr [3];
    logic [31:0] od  [3];

    logic [31:0] exp_q [3][$];
    int          out_cnt [3];
    logic        stall_p [3];
    logic [31:0] stall_d [3];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NB = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        axicb_pipeline_chain #(
            .DATA_BUS_W  (32),
            .NB_PIPELINE (NB)
        ) u_dut (
            .aclk    (aclk),
            .srst    (srst),
            .i_valid (iv[g]),
            .i_ready (ir[g]),
            .i_data  (id[g]),
            .o_valid (ov[g]),
            .o_ready (orr[g]),
            .o_data  (od[g])
        );
    end

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expired(string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_next(logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? 32'h04C11DB7 : 32'h0);
    endfunction

    // Output-side monitor: pops and compares on every output handshake,
    // and checks that a stalled beat is held stable.
    initial begin
        for (int i = 0; i < 3; i++) begin
            out_cnt[i] = 0;
            stall_p[i] = 1'b0;
            stall_d[i] = '0;
        end
        forever begin
            @(negedge aclk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!srst) begin
                    if (i > 0 && stall_p[i]) begin
                        check($sformatf("hold_valid%0d", i), 32'(ov[i]), 32'd1);
                        check($sformatf("hold_data%0d", i), od[i], stall_d[i]);
                    end
                    if (ov[i] && orr[i]) begin
                        out_cnt[i]++;
                        if (exp_q[i].size() == 0) begin
                            expired($sformatf("extra_beat%0d", i));
                        end else begin
                            check($sformatf("beat_data%0d", i), od[i], exp_q[i].pop_front());
                        end
                    end
                end
                stall_p[i] = !srst && ov[i] && !orr[i];
                stall_d[i] = od[i];
            end
        end
    end

    task automatic send(int i, logic [31:0] d);
        bit done = 1'b0;
        iv[i] = 1'b1;
        id[i] = d;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge aclk);
            if (ir[i]) begin
                exp_q[i].push_back(d);
                done = 1'b1;
            end
            tick();
        end
        if (!done) expired($sformatf("send%0d", i));
    endtask

    task automatic stream(int i, int nb);
        int outs  = 0;
        int first = -1;
        int last  = -1;
        int sent  = 0;
        bit acc;
        orr[i] = 1'b1;
        iv[i]  = 1'b1;
        id[i]  = 32'h1000_0000;
        for (int c = 0; c < 1200 && outs < 1000; c++) begin
            @(negedge aclk);
            if (ov[i]) begin
                if (first < 0) first = c;
                last = c;
                outs++;
            end
            acc = iv[i] && ir[i];
            if (acc) begin
                exp_q[i].push_back(id[i]);
                sent++;
            end
            tick();
            if (acc) begin
                if (sent == 1000) iv[i] = 1'b0;
                else id[i] = id[i] + 1;
            end
        end
        iv[i] = 1'b0;
        check($sformatf("stream_count%0d", i), 32'(outs), 32'd1000);
        check($sformatf("stream_latency%0d", i), 32'(first), 32'(nb));
        check($sformatf("stream_rate%0d", i), 32'(last - first), 32'd999);
    endtask

    task automatic random_run();
        logic [31:0] lfsr = KEY;
        int base = out_cnt[2];
        int gap = 0;
        int max_gap = 0;
        bit rst_done = 1'b0;
        bit acc;
        for (int c = 0; c < 40000 && (out_cnt[2] - base) < 5000; c++) begin
            if (!rst_done && (out_cnt[2] - base) >= 2500) begin
                srst  = 1'b1;
                iv[2] = 1'b0;
                exp_q[2].delete();
                tick();
                tick();
                srst = 1'b0;
                rst_done = 1'b1;
                @(negedge aclk);
                check("midrst_ovalid", 32'(ov[2]), 32'd0);
                check("midrst_iready", 32'(ir[2]), 32'd1);
                tick();
            end
            orr[2] = ($urandom_range(0, 3) != 0);
            if (!iv[2]) iv[2] = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 15) == 0) iv[2] = 1'b0;
            id[2] = lfsr;
            @(negedge aclk);
            acc = iv[2] && ir[2];
            if (acc) exp_q[2].push_back(lfsr);
            if (ov[2] && orr[2]) gap = 0;
            else gap++;
            if (gap > max_gap) max_gap = gap;
            tick();
            if (acc) lfsr = lfsr_next(lfsr);
        end
        iv[2] = 1'b0;
        check("rand_handshakes", 32'((out_cnt[2] - base) >= 5000), 32'd1);
        check("rand_max_gap", 32'(max_gap < 10000), 32'd1);
        check("rand_midrst_seen", 32'(rst_done), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        srst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i]  = 1'b0;
            id[i]  = '0;
            orr[i] = 1'b1;
        end

        // reset held for three cycles
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        for (int i = 1; i < 3; i++) begin
            check($sformatf("rst_ovalid%0d", i), 32'(ov[i]), 32'd0);
            check($sformatf("rst_odata%0d", i), od[i], 32'd0);
            check($sformatf("rst_iready%0d", i), 32'(ir[i]), 32'd0);
        end
        @(posedge aclk);
        #1;
        srst = 1'b0;
        @(negedge aclk);
        for (int i = 1; i < 3; i++) begin
            check($sformatf("rel_iready%0d", i), 32'(ir[i]), 32'd1);
            check($sformatf("rel_ovalid%0d", i), 32'(ov[i]), 32'd0);
        end
        tick();

        // single beat through one stage
        send(1, 32'hDEADBEEF);
        iv[1] = 1'b0;
        @(negedge aclk);
        check("single_ovalid", 32'(ov[1]), 32'd1);
        check("single_odata", od[1], 32'hDEADBEEF);
        tick();
        @(negedge aclk);
        check("single_once", 32'(ov[1]), 32'd0);
        tick();

        // back-pressure: two beats fit, the third waits
        orr[1] = 1'b0;
        send(1, 32'd1);
        send(1, 32'd2);
        id[1] = 32'd3;
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            check("bp_iready_full", 32'(ir[1]), 32'd0);
            check("bp_odata_hold", od[1], 32'd1);
            tick();
        end
        orr[1] = 1'b1;
        @(negedge aclk);
        check("bp_out1", od[1], 32'd1);
        check("bp_iready_a", 32'(ir[1]), 32'd0);
        tick();
        @(negedge aclk);
        check("bp_out2", od[1], 32'd2);
        check("bp_iready_b", 32'(ir[1]), 32'd1);
        if (ir[1]) exp_q[1].push_back(32'd3);
        tick();
        iv[1] = 1'b0;
        @(negedge aclk);
        check("bp_out3_valid", 32'(ov[1]), 32'd1);
        check("bp_out3", od[1], 32'd3);
        tick();
        @(negedge aclk);
        check("bp_empty", 32'(ov[1]), 32'd0);
        tick();

        // zero stages: wires
        orr[0] = 1'b0;
        iv[0]  = 1'b1;
        id[0]  = 32'hA5A5_0001;
        @(negedge aclk);
        check("nb0_ovalid", 32'(ov[0]), 32'd1);
        check("nb0_odata", od[0], 32'hA5A5_0001);
        check("nb0_iready_lo", 32'(ir[0]), 32'd0);
        tick();
        orr[0] = 1'b1;
        id[0]  = 32'h5A5A_0002;
        @(negedge aclk);
        check("nb0_iready_hi", 32'(ir[0]), 32'd1);
        check("nb0_odata2", od[0], 32'h5A5A_0002);
        if (ir[0]) exp_q[0].push_back(id[0]);
        tick();
        iv[0] = 1'b0;
        @(negedge aclk);
        check("nb0_idle", 32'(ov[0]), 32'd0);
        tick();

        stream(1, 1);
        stream(2, 3);
        random_run();

        orr[2] = 1'b1;
        repeat (20) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("queue_empty%0d", i), 32'(exp_q[i].size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
